muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Iterative unsigned multiply/divide unit and its controlling state machine, attached beside the execute-stage ALU.
- When an M-type instruction reaches execute, it latches the forwarded operands and runs a radix-2 shift-add multiply or restoring divide for WIDTH cycles.
- It holds the pipeline stalled while running, then presents the result for exactly one cycle so execute can register it into the memory stage.

Parameters:
- WIDTH, 32, operand/result width in bits; also the iteration count.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  reset; asynchronous, active-high.
- StartE  input  1  execute-stage instruction is a mul/div op. Held high while the instruction sits in execute.
- OpE  input  2  operation select. 00 MUL (low product), 01 MULH (high product, unsigned), 10 DIV (quotient), 11 REM (remainder).
- SrcAE  input  WIDTH  forwarded source A (multiplicand / dividend).
- SrcBE  input  WIDTH  forwarded source B (multiplier / divisor).
- FlushE  input  1  kill the execute-stage instruction.
- StallMD  output  1  freeze fetch/decode/execute pipeline registers.
- DoneMD  output  1  ResultMD valid this cycle.
- ResultMD  output  WIDTH  operation result.
- BusyMD  output  1  state is not IDLE (status/debug).

Behaviour:
- Reset (async, rst=1): state=IDLE, counter=0, all datapath registers 0. StallMD=0, DoneMD=0, ResultMD=0, BusyMD=0. Reset mid-operation abandons the operation; no Done is produced.
- States: IDLE, MUL_RUN, DIV_RUN, DONE.
- IDLE, accept condition StartE=1 and FlushE=0:
  - Latch A, B and OpE; clear the counter.
  - Next state: DIV_RUN if OpE[1]=1 and B!=0; DONE if OpE[1]=1 and B==0; otherwise MUL_RUN.
- MUL_RUN:
  - Product register P is 2*WIDTH bits, initialised to {0, B}.
  - Each cycle: if P[0]=1, add A to the upper half with a WIDTH+1-bit carry; then shift the whole register right by 1.
  - Counter increments. After WIDTH iterations, go to DONE.
- DIV_RUN:
  - Remainder R is WIDTH+1 bits (init 0); quotient Q is initialised to A.
  - Each cycle: shift {R,Q} left by 1, then trial-subtract B from R.
  - If the result is non-negative: R = difference, Q[0]=1. Otherwise R is kept and Q[0]=0.
  - After WIDTH iterations, go to DONE.
- Divide by zero (B==0 at accept): bypass iterations. DIV returns all ones, REM returns A. The DONE cycle follows the accept cycle directly (latency 1).
- DONE:
  - DoneMD=1 and ResultMD is selected by the latched op: MUL=P[WIDTH-1:0], MULH=P[2W-1:W], DIV=Q, REM=R[WIDTH-1:0].
  - Unconditional return to IDLE.
  - StartE is ignored in DONE, because the same instruction is still present.
- StallMD is combinational: (IDLE & StartE & ~FlushE) | MUL_RUN | DIV_RUN. It is 0 in DONE, so the pipeline advances on the edge ending DONE.
- Latency, counting the accept cycle as cycle 0:
  - Stall is high in cycles 0..WIDTH.
  - DoneMD is high in cycle WIDTH+1 only (34 cycles total for WIDTH=32).
- DoneMD/ResultMD hold: ResultMD holds its last value outside DONE. DoneMD is a single-cycle pulse.
- FlushE:
  - In any RUN state or DONE: next state IDLE, DoneMD forced 0 in that cycle, StallMD deasserted in that cycle.
  - In IDLE: the accept is suppressed.
- Operands change while running: ignored; only the values latched at accept are used.
- Overflow: MUL discards high bits (wrap); MULH gives the exact high word. All arithmetic is unsigned modulo 2^WIDTH.

Test Plan:
- Reset, then StartE=1, OpE=00, A=7, B=6 -> StallMD=1 in cycles 0..32; DoneMD=1 in cycle 33 with ResultMD=42; cycle 34 back in IDLE.
- MULH with A=B=0xFFFFFFFF -> ResultMD=0xFFFFFFFE at Done. Repeat with MUL on the same operands -> 0x00000001.
- DIV with A=100, B=7 -> 14; REM with the same operands -> 2. Both complete at cycle 33.
- DIV and REM with A=0x1234, B=0 -> Done in cycle 1, StallMD only in cycle 0. Results: DIV 0xFFFFFFFF, REM 0x1234.
- Start MUL, assert FlushE in cycle 10 -> IDLE in cycle 11, no DoneMD pulse. A new DIV accepted in cycle 11 completes normally in cycle 44.
- Assert rst in cycle 15 of a DIV -> outputs 0 immediately (async). After release, DoneMD stays 0 until a new StartE is accepted.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// Handshake bundle between the execute stage and the iterative multiply/divide unit.
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
    logic             StartE;
    logic [1:0]       OpE;
    logic [WIDTH-1:0] SrcAE;
    logic [WIDTH-1:0] SrcBE;
    logic             FlushE;
    logic             StallMD;
    logic             DoneMD;
    logic [WIDTH-1:0] ResultMD;
    logic             BusyMD;

    modport master (
        output StartE, OpE, SrcAE, SrcBE, FlushE,
        input  StallMD, DoneMD, ResultMD, BusyMD
    );

    modport slave (
        input  StartE, OpE, SrcAE, SrcBE, FlushE,
        output StallMD, DoneMD, ResultMD, BusyMD
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative unsigned radix-2 multiply / restoring divide beside the execute-stage ALU.
// Stalls the pipeline while iterating, then presents the result for one DONE cycle.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    muldiv_sequencer_if.slave md
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   count_r;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [2*WIDTH-1:0] p_r;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   q_r;
    logic [WIDTH-1:0]   result_r;

    logic [2*WIDTH-1:0] pNext_s;
    logic [WIDTH-1:0]   remNext_s;
    logic [WIDTH-1:0]   qNext_s;
    logic               lastIter_s;
    logic               accept_s;
    logic               divZero_s;

    function automatic logic [2*WIDTH-1:0] mulStep(input logic [2*WIDTH-1:0] p,
                                                   input logic [WIDTH-1:0]   a);
        logic [WIDTH:0] sum;
        if (p[0]) begin
            sum = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, a};
        end else begin
            sum = {1'b0, p[2*WIDTH-1:WIDTH]};
        end
        return {sum, p[WIDTH-1:1]};
    endfunction

    // The remainder is always below the divisor, so only the trial subtraction needs the extra bit.
    function automatic logic [2*WIDTH-1:0] divStep(input logic [WIDTH-1:0] r,
                                                   input logic [WIDTH-1:0] q,
                                                   input logic [WIDTH-1:0] b);
        logic [WIDTH:0]   shifted;
        logic [WIDTH:0]   diff;
        logic [WIDTH-1:0] qShift;
        shifted = {r, q[WIDTH-1]};
        qShift  = {q[WIDTH-2:0], 1'b0};
        diff    = shifted - {1'b0, b};
        if (diff[WIDTH]) begin
            return {shifted[WIDTH-1:0], qShift};
        end else begin
            return {diff[WIDTH-1:0], qShift[WIDTH-1:1], 1'b1};
        end
    endfunction

    function automatic logic [WIDTH-1:0] selectResult(input logic [1:0]         op,
                                                      input logic [2*WIDTH-1:0] p,
                                                      input logic [WIDTH-1:0]   r,
                                                      input logic [WIDTH-1:0]   q);
        case (op)
            2'b00:   return p[WIDTH-1:0];
            2'b01:   return p[2*WIDTH-1:WIDTH];
            2'b10:   return q;
            default: return r;
        endcase
    endfunction

    // Next-iteration datapath values and accept decode.
    always_comb begin
        pNext_s                = mulStep(p_r, a_r);
        {remNext_s, qNext_s}   = divStep(rem_r, q_r, b_r);
        lastIter_s             = (count_r == CNT_W'(WIDTH - 1));
        accept_s               = md.StartE & ~md.FlushE;
        divZero_s              = (md.SrcBE == {WIDTH{1'b0}});
    end

    // Sequencer FSM with operand latches, iteration datapath and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            count_r  <= {CNT_W{1'b0}};
            op_r     <= 2'b00;
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            p_r      <= {(2*WIDTH){1'b0}};
            rem_r    <= {WIDTH{1'b0}};
            q_r      <= {WIDTH{1'b0}};
            result_r <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r     <= md.SrcAE;
                        b_r     <= md.SrcBE;
                        op_r    <= md.OpE;
                        count_r <= {CNT_W{1'b0}};
                        p_r     <= {{WIDTH{1'b0}}, md.SrcBE};
                        rem_r   <= {WIDTH{1'b0}};
                        q_r     <= md.SrcAE;
                        if (md.OpE[1] && divZero_s) begin
                            // Divide by zero skips iteration: quotient all ones, remainder the dividend.
                            q_r      <= {WIDTH{1'b1}};
                            rem_r    <= md.SrcAE;
                            result_r <= md.OpE[0] ? md.SrcAE : {WIDTH{1'b1}};
                            state_r  <= DONE;
                        end else if (md.OpE[1]) begin
                            state_r <= DIV_RUN;
                        end else begin
                            state_r <= MUL_RUN;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                MUL_RUN: begin
                    if (md.FlushE) begin
                        state_r <= IDLE;
                    end else begin
                        p_r     <= pNext_s;
                        count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (lastIter_s) begin
                            result_r <= selectResult(op_r, pNext_s, rem_r, q_r);
                            state_r  <= DONE;
                        end else begin
                            state_r <= MUL_RUN;
                        end
                    end
                end
                DIV_RUN: begin
                    if (md.FlushE) begin
                        state_r <= IDLE;
                    end else begin
                        rem_r   <= remNext_s;
                        q_r     <= qNext_s;
                        count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (lastIter_s) begin
                            result_r <= selectResult(op_r, p_r, remNext_s, qNext_s);
                            state_r  <= DONE;
                        end else begin
                            state_r <= DIV_RUN;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Stall drops in DONE so the pipeline advances on the edge that ends it.
    assign md.StallMD  = ~rst & ~md.FlushE &
                         (((state_r == IDLE) & md.StartE) |
                          (state_r == MUL_RUN) | (state_r == DIV_RUN));
    assign md.DoneMD   = (state_r == DONE) & ~md.FlushE;
    assign md.ResultMD = result_r;
    assign md.BusyMD   = (state_r != IDLE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: latency, results, divide-by-zero, flush and reset.
module tb_muldiv_sequencer;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst;
    int   nChecks = 0;
    int   nFails  = 0;
    logic [WIDTH-1:0] expQ[$];

    muldiv_sequencer_if #(.WIDTH(WIDTH)) md();

    muldiv_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk(clk),
        .rst(rst),
        .md (md)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] model(input logic [1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] prod;
        prod = 64'(a) * 64'(b);
        case (op)
            2'b00:   return prod[WIDTH-1:0];
            2'b01:   return prod[2*WIDTH-1:WIDTH];
            2'b10:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Called just after a falling edge; the accept cycle is cycle 0.
    task automatic doOp(input logic [1:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input string name);
        int               lat;
        logic [WIDTH-1:0] expVal;
        logic [WIDTH-1:0] got;
        lat    = (op[1] && b == 32'd0) ? 1 : WIDTH + 1;
        expVal = model(op, a, b);
        md.StartE = 1'b1;
        md.OpE    = op;
        md.SrcAE  = a;
        md.SrcBE  = b;
        md.FlushE = 1'b0;
        expQ.push_back(expVal);
        for (int cyc = 0; cyc <= lat; cyc++) begin
            #1;
            nChecks++;
            if (md.StallMD !== (cyc < lat)) begin
                nFails++;
                $display("FAIL %s stall cycle %0d: got %b want %b", name, cyc, md.StallMD, (cyc < lat));
            end
            nChecks++;
            if (md.DoneMD !== (cyc == lat)) begin
                nFails++;
                $display("FAIL %s done cycle %0d: got %b want %b", name, cyc, md.DoneMD, (cyc == lat));
            end
            if (md.DoneMD === 1'b1) begin
                nChecks++;
                if (expQ.size() == 0) begin
                    nFails++;
                    $display("FAIL %s unexpected done cycle %0d: result %h, nothing expected", name, cyc, md.ResultMD);
                end else begin
                    got = expQ.pop_front();
                    if (md.ResultMD !== got) begin
                        nFails++;
                        $display("FAIL %s result: got %h want %h", name, md.ResultMD, got);
                    end
                end
            end
            if (cyc == 3) begin
                md.SrcAE = ~a;
                md.SrcBE = a ^ b ^ 32'h5A5A_5A5A;
                md.OpE   = ~op;
            end
            @(negedge clk);
        end
        md.StartE = 1'b0;
        #1;
        nChecks++;
        if (md.BusyMD !== 1'b0 || md.StallMD !== 1'b0 || md.DoneMD !== 1'b0) begin
            nFails++;
            $display("FAIL %s idle after done: got busy=%b stall=%b done=%b want 0 0 0",
                     name, md.BusyMD, md.StallMD, md.DoneMD);
        end
        nChecks++;
        if (md.ResultMD !== expVal) begin
            nFails++;
            $display("FAIL %s result hold: got %h want %h", name, md.ResultMD, expVal);
        end
        nChecks++;
        if (expQ.size() != 0) begin
            nFails++;
            $display("FAIL %s missing done: got %0d pending want 0", name, expQ.size());
            expQ.delete();
        end
    endtask

    task automatic checkAllZero(input string name);
        nChecks++;
        if (md.StallMD !== 1'b0 || md.DoneMD !== 1'b0 || md.BusyMD !== 1'b0 || md.ResultMD !== 32'd0) begin
            nFails++;
            $display("FAIL %s: got stall=%b done=%b busy=%b result=%h want all zero",
                     name, md.StallMD, md.DoneMD, md.BusyMD, md.ResultMD);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        md.StartE = 1'b1;
        md.OpE    = 2'b00;
        md.SrcAE  = 32'd3;
        md.SrcBE  = 32'd4;
        md.FlushE = 1'b0;
        @(negedge clk);
        #1;
        checkAllZero("reset_held");
        @(negedge clk);
        md.StartE = 1'b0;
        rst       = 1'b0;
        #1;
        checkAllZero("reset_released");
    endtask

    task automatic test_mul();
        @(negedge clk);
        doOp(2'b00, 32'd7, 32'd6, "mul_7x6");
        @(negedge clk);
        doOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh_max");
        @(negedge clk);
        doOp(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max_wrap");
    endtask

    task automatic test_div();
        @(negedge clk);
        doOp(2'b10, 32'd100, 32'd7, "div_100_7");
        @(negedge clk);
        doOp(2'b11, 32'd100, 32'd7, "rem_100_7");
        @(negedge clk);
        doOp(2'b10, 32'd5, 32'd9, "div_small");
    endtask

    task automatic test_div_zero();
        @(negedge clk);
        doOp(2'b10, 32'h1234, 32'd0, "div_by_zero");
        @(negedge clk);
        doOp(2'b11, 32'h1234, 32'd0, "rem_by_zero");
    endtask

    task automatic test_flush();
        @(negedge clk);
        md.StartE = 1'b1;
        md.OpE    = 2'b00;
        md.SrcAE  = 32'd3;
        md.SrcBE  = 32'd5;
        md.FlushE = 1'b0;
        for (int cyc = 0; cyc <= 10; cyc++) begin
            if (cyc == 10) md.FlushE = 1'b1;
            #1;
            nChecks++;
            if (md.StallMD !== (cyc < 10) || md.DoneMD !== 1'b0) begin
                nFails++;
                $display("FAIL flush cycle %0d: got stall=%b done=%b want %b 0", cyc, md.StallMD, md.DoneMD, (cyc < 10));
            end
            @(negedge clk);
        end
        md.FlushE = 1'b0;
        md.StartE = 1'b0;
        #1;
        nChecks++;
        if (md.BusyMD !== 1'b0 || md.DoneMD !== 1'b0) begin
            nFails++;
            $display("FAIL flush_to_idle: got busy=%b done=%b want 0 0", md.BusyMD, md.DoneMD);
        end
        doOp(2'b10, 32'd1000, 32'd33, "div_after_flush");
    endtask

    task automatic test_rst_midop();
        logic sawDone;
        @(negedge clk);
        md.StartE = 1'b1;
        md.OpE    = 2'b10;
        md.SrcAE  = 32'd1000;
        md.SrcBE  = 32'd3;
        repeat (15) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkAllZero("reset_midop_async");
        @(negedge clk);
        @(negedge clk);
        rst       = 1'b0;
        md.StartE = 1'b0;
        sawDone   = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            if (md.DoneMD !== 1'b0 || md.BusyMD !== 1'b0) sawDone = 1'b1;
            @(negedge clk);
        end
        nChecks++;
        if (sawDone !== 1'b0) begin
            nFails++;
            $display("FAIL reset_abandon: got activity=%b want 0", sawDone);
        end
        doOp(2'b11, 32'd1000, 32'd3, "rem_after_reset");
    endtask

    task automatic test_back_to_back();
        logic [1:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            if (i % 4 == 3) b = 32'd0;
            else            b = $urandom >> $urandom_range(0, 31);
            doOp(op, a, b, "b2b_random");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_flush();
        test_rst_midop();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
